// File: rtl/ssd_pkg.sv
// Shared constants and the active-low seven-segment table for display blocks.
package ssd_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam int         PWM_BITS  = 4;

    // Active-low {a,b,c,d,e,f,g} pattern for one hex nibble.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            4'hF:    seg = 7'b0111000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/ssd_hex_decode.sv
// Combinational nibble + decimal point to active-low cathode pattern.
module ssd_hex_decode
    import ssd_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] cathodes
);

    // Segments in [7:1], decimal point (active-low) in [0].
    always_comb begin
        cathodes = {seg_decode(nibble), ~dp};
    end

endmodule

// File: rtl/ssd_scan_driver.sv
// N-digit multiplexed seven-segment driver with frame-synchronous double buffering,
// leading-zero blanking and PWM brightness.
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS    = 8,
    parameter int SCAN_BITS     = 18,
    parameter int BLANK_LEADING = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [3:0]              bright_lvl,
    output logic [NUM_DIGITS-1:0]   anodes,
    output logic [7:0]              cathodes,
    output logic                    pending,
    output logic                    frame_done
);

    localparam int              IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic [SCAN_BITS-1:0]    presc_r;
    logic [IDX_W-1:0]        idx_r;
    logic [4*NUM_DIGITS-1:0] act_val_r;
    logic [4*NUM_DIGITS-1:0] shd_val_r;
    logic [NUM_DIGITS-1:0]   act_dp_r;
    logic [NUM_DIGITS-1:0]   shd_dp_r;
    logic                    pending_r;
    logic                    frame_done_r;
    logic [NUM_DIGITS-1:0]   anodes_r;
    logic [7:0]              cathodes_r;

    logic                    tick_s;
    logic                    boundary_s;
    logic                    pwm_on_s;
    logic [NUM_DIGITS-1:0]   blank_vec_s;
    logic [NUM_DIGITS-1:0]   sel_s;
    logic [NUM_DIGITS-1:0]   anode_nxt_s;
    logic [3:0]              nib_s;
    logic                    dp_s;
    logic                    en_s;
    logic                    blank_s;
    logic                    light_s;
    logic [7:0]              dec_s;

    assign tick_s     = &presc_r;
    assign boundary_s = tick_s & (idx_r == LAST_IDX);
    assign pwm_on_s   = (presc_r[SCAN_BITS-1 -: PWM_BITS] <= bright_lvl);

    // A digit is blank when it and every more significant nibble are zero and its dp is dark.
    always_comb begin
        logic zero_run_v;
        zero_run_v  = 1'b1;
        blank_vec_s = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run_v     = zero_run_v & (act_val_r[4*i +: 4] == 4'h0);
            blank_vec_s[i] = (BLANK_LEADING != 0) && (i != 0) && zero_run_v && !act_dp_r[i];
        end
    end

    // Select the current digit's data and form the next anode vector; at most one bit is low.
    always_comb begin
        nib_s   = 4'h0;
        dp_s    = 1'b0;
        en_s    = 1'b0;
        blank_s = 1'b0;
        sel_s   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            sel_s[i] = (idx_r == IDX_W'(i));
            nib_s    = nib_s | ({4{sel_s[i]}} & act_val_r[4*i +: 4]);
            dp_s     = dp_s | (sel_s[i] & act_dp_r[i]);
            en_s     = en_s | (sel_s[i] & digit_en[i]);
            blank_s  = blank_s | (sel_s[i] & blank_vec_s[i]);
        end
        light_s = en_s & pwm_on_s & ~blank_s;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            anode_nxt_s[i] = ~(light_s & sel_s[i]);
        end
    end

    ssd_hex_decode u_dec (
        .nibble   (nib_s),
        .dp       (dp_s),
        .cathodes (dec_s)
    );

    // Prescaler, digit index and frame pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r      <= '0;
            idx_r        <= '0;
            frame_done_r <= 1'b0;
        end else begin
            presc_r      <= presc_r + SCAN_BITS'(1);
            frame_done_r <= boundary_s;
            if (tick_s) begin
                idx_r <= (idx_r == LAST_IDX) ? '0 : idx_r + IDX_W'(1);
            end
        end
    end

    // Shadow/active buffers; a load on the boundary cycle stays pending for the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_val_r <= '0;
            act_dp_r  <= '0;
            shd_val_r <= '0;
            shd_dp_r  <= '0;
            pending_r <= 1'b0;
        end else begin
            if (boundary_s && pending_r) begin
                act_val_r <= shd_val_r;
                act_dp_r  <= shd_dp_r;
            end
            if (load) begin
                shd_val_r <= value;
                shd_dp_r  <= dp_in;
                pending_r <= 1'b1;
            end else if (boundary_s) begin
                pending_r <= 1'b0;
            end
        end
    end

    // Registered pin drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            anodes_r   <= '1;
            cathodes_r <= SEG_BLANK;
        end else begin
            anodes_r   <= anode_nxt_s;
            cathodes_r <= light_s ? dec_s : SEG_BLANK;
        end
    end

    assign anodes     = anodes_r;
    assign cathodes   = cathodes_r;
    assign pending    = pending_r;
    assign frame_done = frame_done_r;

endmodule
